// File: rtl/ping_pong_buf_pkg.sv
// rtl/ping_pong_buf_pkg.sv - shared constants and types for the ping-pong buffer
//
// Purpose: default geometry of the buffer and the read-side state encoding,
// shared by the top level and its bank RAMs.
package ping_pong_buf_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_DEPTH  = 1024;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

endpackage

// File: rtl/pp_bank_ram.sv
// rtl/pp_bank_ram.sv - simple dual-port bank RAM with registered read
//
// Purpose: one DEPTH x DATA_W bank. One write port and one synchronous read
// port. rd_data updates one cycle after rd_en and holds its value while rd_en
// is low.
// Ports:
//   fclk     - clock, rising edge
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write word
//   rd_en    - read strobe
//   rd_addr  - read address
//   rd_data  - registered read word
module pp_bank_ram
   import ping_pong_buf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              fclk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are never reset; stale words are unreachable once the full
   // flags in the top level are cleared.
   always_ff @(posedge fclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/ping_pong_buf.sv
// rtl/ping_pong_buf.sv - two-bank ping-pong packet buffer, stream in / stream out
//
// Purpose: the writer fills one bank while the reader drains the other. A bank
// closes on the last word of a packet or when it is full (overlong packets are
// cut at DEPTH words). A closed bank is read out in address order once
// i_swap_ok grants it.
// Ports:
//   i_clk, i_rstn            - clock, synchronous active-low reset
//   i_s_valid/i_s_data/i_s_last, o_s_ready - write-side stream
//   o_m_valid/o_m_data/o_m_last, i_m_ready - read-side stream
//   i_swap_ok                - permission to start reading a full bank
module ping_pong_buf
   import ping_pong_buf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_s_valid,
   input  logic [DATA_W-1:0] i_s_data,
   input  logic              i_s_last,
   output logic              o_s_ready,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_last,
   input  logic              i_swap_ok
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [1:0]        full;
   logic [LW-1:0]     len [2];
   logic              wr_sel;
   logic              rd_sel;
   logic [AW-1:0]     wr_addr;
   logic [AW-1:0]     rd_addr;
   rd_state_t         state;
   rd_state_t         state_nxt;

   logic              wr_accept;
   logic              wr_close;
   logic              rd_start;
   logic              rd_hs;
   logic              rd_is_last;
   logic              rd_done;
   logic              rd_fetch;
   logic [AW-1:0]     fetch_addr;
   logic [1:0][DATA_W-1:0] bank_q;

   // ---------------- write side ----------------
   assign o_s_ready = ~full[wr_sel];
   assign wr_accept = i_s_valid & o_s_ready;
   assign wr_close  = wr_accept & (i_s_last | (wr_addr == LAST_ADDR));

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wr_sel  <= 1'b0;
         wr_addr <= '0;
      end else if (wr_accept) begin
         if (wr_close) begin
            wr_sel  <= ~wr_sel;
            wr_addr <= '0;
         end else begin
            wr_addr <= wr_addr + AW'(1);
         end
      end
   end

   // Length is only consulted while the bank is full, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (wr_close) begin
         len[wr_sel] <= {1'b0, wr_addr} + LW'(1);
      end
   end

   // The writer only closes a non-full bank and the reader only frees a full
   // one, so a simultaneous close and free always touch different banks.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         full <= 2'b00;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_close && (wr_sel == 1'(b))) begin
               full[b] <= 1'b1;
            end else if (rd_done && (rd_sel == 1'(b))) begin
               full[b] <= 1'b0;
            end
         end
      end
   end

   // ---------------- read side ----------------
   // rd_addr is the index of the word currently presented. The RAM is read one
   // word ahead: word 0 on the IDLE->STREAM transition, word n+1 on the
   // handshake of word n, so data is back-to-back with i_m_ready high and the
   // RAM output simply holds during a stall.
   assign o_m_valid  = (state == STREAM);
   assign rd_is_last = ({1'b0, rd_addr} == (len[rd_sel] - LW'(1)));
   assign rd_hs      = o_m_valid & i_m_ready;
   assign rd_done    = rd_hs & rd_is_last;
   assign rd_fetch   = rd_start | (rd_hs & ~rd_is_last);
   assign fetch_addr = rd_start ? '0 : (rd_addr + AW'(1));

   always_comb begin
      state_nxt = state;
      rd_start  = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_sel] && i_swap_ok) begin
               state_nxt = STREAM;
               rd_start  = 1'b1;
            end
         end
         STREAM: begin
            if (rd_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state   <= IDLE;
         rd_sel  <= 1'b0;
         rd_addr <= '0;
      end else begin
         state <= state_nxt;
         if (rd_start) begin
            rd_addr <= '0;
         end else if (rd_hs) begin
            if (rd_is_last) begin
               rd_addr <= '0;
               rd_sel  <= ~rd_sel;
            end else begin
               rd_addr <= rd_addr + AW'(1);
            end
         end
      end
   end

   // The RAM output register is not reset; masking with valid gives zero data
   // out of reset and between readouts.
   assign o_m_data = o_m_valid ? bank_q[rd_sel] : '0;
   assign o_m_last = o_m_valid & rd_is_last;

   // ---------------- storage ----------------
   for (genvar b = 0; b < 2; b++) begin : g_bank
      pp_bank_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .AW     (AW)
      ) u_bank (
         .fclk    (i_clk),
         .wr_en   (wr_accept & (wr_sel == 1'(b))),
         .wr_addr (wr_addr),
         .wr_data (i_s_data),
         .rd_en   (rd_fetch & (rd_sel == 1'(b))),
         .rd_addr (fetch_addr),
         .rd_data (bank_q[b])
      );
   end

endmodule

// File: tb/tb_ping_pong_buf.sv
// tb/tb_ping_pong_buf.sv - self-checking bench for ping_pong_buf
module tb_ping_pong_buf;

   localparam int DW    = 12;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          s_ready;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          swap_ok;

   always #5 clk = ~clk;

   ping_pong_buf #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_s_valid (s_valid),
      .i_s_data  (s_data),
      .i_s_last  (s_last),
      .o_s_ready (s_ready),
      .o_m_valid (m_valid),
      .i_m_ready (m_ready),
      .o_m_data  (m_data),
      .o_m_last  (m_last),
      .i_swap_ok (swap_ok)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Closed packets waiting or being read, as one flat word list plus a list
   // of lengths. The writer may accept while fewer than two packets are held.
   int fill_q[$];
   int pend_words[$];
   int pend_len[$];
   int log_q[$];
   bit reading = 0;
   int since   = 0;
   int idx     = 0;
   bit armed   = 0;
   bit m_start, m_hs, m_acc, exp_ready;

   always @(negedge clk) begin
      exp_ready = (pend_len.size() < 2);
      if (armed) begin
         if (reading) since++;
         check("s_ready", int'(s_ready), int'(exp_ready));
         if (!reading) begin
            check("m_valid_idle", int'(m_valid), 0);
         end else if (since >= 2) begin
            check("m_valid_stream", int'(m_valid), 1);
         end
         if (reading && m_valid) begin
            check("m_data", int'(m_data), pend_words[idx]);
            check("m_last", int'(m_last), int'(idx == pend_len[0] - 1));
         end
      end
      if (!rstn) begin
         fill_q.delete();
         pend_words.delete();
         pend_len.delete();
         reading = 0;
         since   = 0;
         idx     = 0;
         armed   = 1;
      end else if (armed) begin
         m_start = !reading && (pend_len.size() > 0) && swap_ok;
         m_hs    = reading && m_valid && m_ready;
         m_acc   = s_valid && exp_ready;
         if (m_hs) begin
            log_q.push_back(int'({m_last, m_data}));
            if (idx == pend_len[0] - 1) begin
               for (int k = 0; k < pend_len[0]; k++) void'(pend_words.pop_front());
               void'(pend_len.pop_front());
               reading = 0;
               idx     = 0;
            end else begin
               idx++;
            end
         end
         if (m_start) begin
            reading = 1;
            since   = 0;
            idx     = 0;
         end
         if (m_acc) begin
            fill_q.push_back(int'(s_data));
            if (s_last || fill_q.size() == DEPTH) begin
               foreach (fill_q[k]) pend_words.push_back(fill_q[k]);
               pend_len.push_back(fill_q.size());
               fill_q.delete();
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic write_words(input int n, input int base, input bit with_last);
      bit acc;
      int guard;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(base + i);
         s_last  = with_last && (i == n - 1);
         guard   = 0;
         do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            guard++;
         end while (!acc && guard < 100);
         if (!acc) check("write_timeout", 0, 1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_log(input int n, input string name);
      int g;
      g = 0;
      while (log_q.size() < n && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      check(name, log_q.size(), n);
   endtask

   task automatic pulse_swap();
      @(posedge clk);
      #1 swap_ok = 1'b1;
      @(posedge clk);
      #1 swap_ok = 1'b0;
   endtask

   int exp_t2 [5] = '{'h0A1, 'h0A2, 'h10A3, 'h0B1, 'h10B2};
   int g5;

   initial begin
      rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      m_ready = 1'b0; swap_ok = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", int'(s_ready), 1);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data",  int'(m_data), 0);
      check("rst_m_last",  int'(m_last), 0);
      @(posedge clk);
      #1 rstn = 1'b1;

      // pass-through of one 4-word packet
      log_q.delete();
      swap_ok = 1'b1; m_ready = 1'b1;
      write_words(4, 'h001, 1'b1);
      wait_log(4, "t1_count");
      for (int i = 0; i < 4; i++)
         check("t1_word", log_q[i], ((i == 3) ? 'h1000 : 0) | (i + 1));
      repeat (3) @(posedge clk);
      #1 check("t1_idle", int'(m_valid), 0);

      // two packets parked, then drained with a toggling consumer
      log_q.delete();
      swap_ok = 1'b0; m_ready = 1'b0;
      write_words(3, 'h0A1, 1'b1);
      write_words(2, 'h0B1, 1'b1);
      @(negedge clk);
      check("t2_ready_low", int'(s_ready), 0);
      swap_ok = 1'b1;
      for (int c = 0; c < 200 && log_q.size() < 5; c++) begin
         @(posedge clk);
         #1 m_ready = ~m_ready;
      end
      check("t2_count", log_q.size(), 5);
      for (int i = 0; i < 5; i++) check("t2_word", log_q[i], exp_t2[i]);
      swap_ok = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // swap gating
      log_q.delete();
      write_words(2, 'h2C0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_gated", int'(m_valid), 0);
      end
      pulse_swap();
      wait_log(2, "t3_count");
      check("t3_w0", log_q[0], 'h2C0);
      check("t3_w1", log_q[1], 'h12C1);
      repeat (3) @(posedge clk);
      #1;

      // truncation at DEPTH
      log_q.delete();
      write_words(10, 'h100, 1'b0);
      @(negedge clk);
      check("t4_ready", int'(s_ready), 1);
      pulse_swap();
      wait_log(8, "t4_count");
      for (int i = 0; i < 8; i++)
         check("t4_word", log_q[i], ((i == 7) ? 'h1000 : 0) | ('h100 + i));
      repeat (5) @(posedge clk);
      #1 check("t4_bank1_wait", int'(m_valid), 0);
      log_q.delete();
      write_words(1, 'h1FF, 1'b1);
      pulse_swap();
      wait_log(3, "t4b_count");
      check("t4b_w0", log_q[0], 'h108);
      check("t4b_w1", log_q[1], 'h109);
      check("t4b_w2", log_q[2], 'h11FF);
      repeat (3) @(posedge clk);
      #1;

      // reset during a readout
      log_q.delete();
      swap_ok = 1'b1; m_ready = 1'b0;
      write_words(4, 'h300, 1'b1);
      g5 = 0;
      while (!m_valid && g5 < 20) begin
         @(posedge clk);
         #1 g5++;
      end
      check("t5_stream", int'(m_valid), 1);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("t5_valid_after_rst", int'(m_valid), 0);
      check("t5_ready_after_rst", int'(s_ready), 1);
      rstn = 1'b1; m_ready = 1'b1;
      log_q.delete();
      write_words(2, 'h3A0, 1'b1);
      wait_log(2, "t5_count");
      check("t5_w0", log_q[0], 'h3A0);
      check("t5_w1", log_q[1], 'h13A1);

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ping_pong_buf.md
PING_PONG_BUF -- requirements
Module: ping_pong_buf

Interface
REQ-001 Parameter DATA_W, default 12: width of a data word.
REQ-002 Parameter DEPTH, default 1024: words per bank; address width is clog2(DEPTH).
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-004 Port i_clk, in, 1: the single clock; all logic is on its rising edge.
REQ-005 Port i_rstn, in, 1: synchronous active-low reset.
REQ-006 Port i_s_valid, in, 1: the write-side stream word is valid.
REQ-007 Port i_s_data, in, DATA_W: the write-side stream word.
REQ-008 Port i_s_last, in, 1: marks the final word of a packet.
REQ-009 Port o_s_ready, out, 1: the buffer can accept a write-side word.
REQ-010 Port o_m_valid, out, 1: the read-side word is valid.
REQ-011 Port i_m_ready, in, 1: the downstream consumer accepts the read-side word.
REQ-012 Port o_m_data, out, DATA_W: the read-side word.
REQ-013 Port o_m_last, out, 1: marks the final word of a bank readout.
REQ-014 Port i_swap_ok, in, 1: permission to start reading a full bank.

Function
REQ-015 Storage SHALL be two banks (0, 1) of DEPTH x DATA_W words, each with a full flag and a stored length.
REQ-016 The write side SHALL have a bank pointer wr_sel and an address wr_addr.
- o_s_ready = ~full[wr_sel].
- A beat is accepted when i_s_valid & o_s_ready; it writes bank[wr_sel][wr_addr].
REQ-017 An accepted beat SHALL close the bank when i_s_last=1 or wr_addr==DEPTH-1.
- Closing sets full[wr_sel]=1 and len[wr_sel]=wr_addr+1.
- Closing toggles wr_sel and clears wr_addr.
- Otherwise an accepted beat increments wr_addr.
REQ-018 Overlong packets SHALL be truncated at DEPTH: the DEPTH-th word closes the bank, and the following words start the next bank.
REQ-019 The read side SHALL have a bank pointer rd_sel, an address rd_addr and a state machine with states IDLE and STREAM.
REQ-020 IDLE transitions to STREAM in a cycle where full[rd_sel]=1 and i_swap_ok=1. i_swap_ok is ignored in STREAM.
REQ-021 The first word SHALL appear with o_m_valid=1 no later than 2 cycles after the IDLE->STREAM transition.
REQ-022 In STREAM, words SHALL be presented in address order 0..len-1. With i_m_ready held high, one word SHALL be transferred per cycle with no bubbles.
REQ-023 While o_m_valid=1 and i_m_ready=0, o_m_data and o_m_last SHALL hold stable.
REQ-024 o_m_last SHALL be 1 exactly on word len-1.
REQ-025 The handshake of the last word SHALL clear full[rd_sel], toggle rd_sel, and return the FSM to IDLE.
REQ-026 o_m_valid SHALL be 0 in IDLE.
REQ-027 Write and read SHALL never address the same bank. If write closes one bank in the same cycle read frees the other, both updates take effect.
REQ-028 When both banks are full, o_s_ready=0 until a readout completes; a release of the writer's bank takes effect in the next cycle.

Reset
REQ-029 While i_rstn=0 at a clock edge, the following SHALL reset:
- full[1:0]=0, wr_sel=0, rd_sel=0, wr_addr=0, rd_addr=0;
- the FSM SHALL return to IDLE;
- o_m_valid=0, o_m_last=0, o_m_data=0;
- o_s_ready=1 from the first cycle after reset.
REQ-030 Reset mid-packet or mid-readout SHALL discard all buffered data. RAM contents need not reset.

Structure
REQ-031 A shared package SHALL hold:
- the default DATA_W and DEPTH constants;
- the read-FSM state enum (IDLE, STREAM).
REQ-032 A sub-module pp_bank_ram SHALL provide simple dual-port RAM with one write port, one synchronous-read port and a 1-cycle read latency. It is instantiated once per bank.

Verification
REQ-033 After reset, o_s_ready=1 and o_m_valid=0.
REQ-034 Basic pass-through: write 4 words 0x001..0x004 (last on 0x004), i_swap_ok=1, i_m_ready=1 -> read out 0x001..0x004 in order, o_m_last only on 0x004, then IDLE.
REQ-035 Ping-pong and backpressure: write packet A (3 words) and packet B (2 words) with i_m_ready=0 and i_swap_ok=0.
- o_s_ready drops after B.
- With i_swap_ok=1 and i_m_ready toggled, A streams then B, with data stable during stalls.
REQ-036 Swap gating: with a full bank and i_swap_ok=0 for 10 cycles -> o_m_valid stays 0. Pulsing i_swap_ok=1 for one cycle -> the readout starts.
REQ-037 Truncation, with DEPTH=8: write 10 words without last.
- Bank 0 closes at word 8, with o_m_last on word 8.
- Words 9-10 are pending in bank 1.
REQ-038 Reset mid-readout: assert i_rstn=0 during STREAM -> o_m_valid=0 next cycle, both banks empty, and a new packet round-trips correctly.
